// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: fixed priority for p0 with a starvation guard for p1,
// address legality checks, lane steering for stores and routing of read/error responses.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [1:0]  p0_size,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    output logic        p0_err,

    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [1:0]  p1_size,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic        p1_err,

    output logic        mem_en,
    output logic [11:0] mem_addr,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic {
        RESP_IDLE,
        RESP_DUE
    } resp_state_t;

    logic [3:0]  starve_cnt;
    logic        starved;
    logic        any_gnt;
    logic        sel_we;
    logic [1:0]  sel_size;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        aligned;
    logic        legal;
    logic        access;
    logic        needs_resp;
    logic        unused_addr_bits;

    resp_state_t resp_state;
    logic        resp_tag;
    logic        resp_read;
    logic        resp_err;

    assign starved = (starve_cnt == LIMIT);

    // Grants are forced low while reset is asserted so nothing reaches memory.
    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (rst_n) begin
            if (p1_req && (!p0_req || starved)) begin
                p1_gnt = 1'b1;
            end else if (p0_req) begin
                p0_gnt = 1'b1;
            end
        end
    end

    assign any_gnt   = p0_gnt | p1_gnt;
    assign sel_we    = p1_gnt ? p1_we    : p0_we;
    assign sel_size  = p1_gnt ? p1_size  : p0_size;
    assign sel_addr  = p1_gnt ? p1_addr  : p0_addr;
    assign sel_wdata = p1_gnt ? p1_wdata : p0_wdata;

    always_comb begin
        aligned = 1'b1;
        case (sel_size)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~sel_addr[0];
            default: aligned = (sel_addr[1:0] == 2'b00);
        endcase
    end

    assign legal      = ~sel_addr[31] & sel_addr[29] & aligned;
    assign access     = any_gnt & legal;
    assign needs_resp = any_gnt & (~sel_we | ~legal);

    assign unused_addr_bits = ^{sel_addr[30], sel_addr[28:14]};

    // Store data is steered onto the byte lanes selected by the low address bits.
    always_comb begin
        mem_en    = 1'b0;
        mem_addr  = 12'h000;
        mem_wmask = 4'b0000;
        mem_wdata = 32'h0000_0000;
        if (access) begin
            mem_en   = 1'b1;
            mem_addr = sel_addr[13:2];
            if (sel_we) begin
                case (sel_size)
                    2'b00: begin
                        mem_wmask = 4'b0001 << sel_addr[1:0];
                        mem_wdata = sel_wdata << {sel_addr[1:0], 3'b000};
                    end
                    2'b01: begin
                        if (sel_addr[1]) begin
                            mem_wmask = 4'b1100;
                            mem_wdata = {sel_wdata[15:0], 16'h0000};
                        end else begin
                            mem_wmask = 4'b0011;
                            mem_wdata = sel_wdata;
                        end
                    end
                    default: begin
                        mem_wmask = 4'b1111;
                        mem_wdata = sel_wdata;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 4'd0;
        end else if (!p1_req || p1_gnt) begin
            starve_cnt <= 4'd0;
        end else if (!starved) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // One-deep response pipeline; the tag remembers which port the response belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_state <= RESP_IDLE;
            resp_tag   <= 1'b0;
            resp_read  <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            case (resp_state)
                RESP_IDLE, RESP_DUE: begin
                    if (needs_resp) begin
                        resp_state <= RESP_DUE;
                        resp_tag   <= p1_gnt;
                        resp_read  <= ~sel_we;
                        resp_err   <= ~legal;
                    end else begin
                        resp_state <= RESP_IDLE;
                        resp_tag   <= 1'b0;
                        resp_read  <= 1'b0;
                        resp_err   <= 1'b0;
                    end
                end
                default: begin
                    resp_state <= RESP_IDLE;
                    resp_tag   <= 1'b0;
                    resp_read  <= 1'b0;
                    resp_err   <= 1'b0;
                end
            endcase
        end
    end

    assign p0_rvalid = (resp_state == RESP_DUE) & ~resp_tag & resp_read;
    assign p1_rvalid = (resp_state == RESP_DUE) &  resp_tag & resp_read;
    assign p0_err    = (resp_state == RESP_DUE) & ~resp_tag & resp_err;
    assign p1_err    = (resp_state == RESP_DUE) &  resp_tag & resp_err;

    // Rejected reads still return a response, but with zero data.
    assign p0_rdata  = (p0_rvalid && !resp_err) ? mem_rdata : 32'h0000_0000;
    assign p1_rdata  = (p1_rvalid && !resp_err) ? mem_rdata : 32'h0000_0000;

endmodule
